z80fi_insn_collector: RTL

- Sequential capture stage directly upstream of every z80fi_insn_spec_* checker.
- Watches the core's instruction-byte fetch stream and start/retire strobes.
- Assembles opcode bytes into a little-endian instruction word and snapshots register state at instruction start and at retirement.
- Emits one single-cycle z80fi_valid retirement record per completed instruction.

---
 rtl/z80fi_insn_collector_pkg.sv | 15 +
 rtl/z80fi_insn_collector_if.sv | 55 +++++
 rtl/z80fi_insn_collector_byte_buf.sv | 58 +++++
 rtl/z80fi_insn_collector.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/z80fi_insn_collector_pkg.sv
// rtl/z80fi_insn_collector_pkg.sv - shared types and widths for the z80fi instruction collector
// State encoding, default capture depth and record field widths used by every file of the block.
package z80fi_insn_collector_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int MAX_LEN_DEFAULT = 4;
  localparam int LEN_W           = 3;
  localparam int REG8_W          = 8;
  localparam int REG16_W         = 16;

endpackage

// File: rtl/z80fi_insn_collector_if.sv
// rtl/z80fi_insn_collector_if.sv - fetch/retire inputs and retirement record bundle
// master = core side driving fetch strobes, slave = collector; collect_err exists only with Z80FI_COLLECT_CHECK_EN.
interface z80fi_insn_collector_if
  import z80fi_insn_collector_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) ();

  logic                   insn_start;
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   insn_done;
  logic [REG8_W-1:0]      reg_a_cur;
  logic [REG8_W-1:0]      reg_f_cur;
  logic [REG16_W-1:0]     reg_hl_cur;
  logic [REG16_W-1:0]     reg_ip_cur;

  logic                   z80fi_valid;
  logic [8*MAX_LEN-1:0]   z80fi_insn;
  logic [LEN_W-1:0]       z80fi_insn_len;
  logic [REG8_W-1:0]      z80fi_reg_a_in;
  logic [REG8_W-1:0]      z80fi_reg_f_in;
  logic [REG16_W-1:0]     z80fi_reg_hl_in;
  logic [REG16_W-1:0]     z80fi_reg_ip_in;
  logic [REG8_W-1:0]      z80fi_reg_a_out;
  logic [REG8_W-1:0]      z80fi_reg_f_out;
  logic [REG16_W-1:0]     z80fi_reg_hl_out;
  logic [REG16_W-1:0]     z80fi_reg_ip_out;
`ifdef Z80FI_COLLECT_CHECK_EN
  logic                   collect_err;
`endif

  modport master (
    output insn_start, byte_valid, byte_data, insn_done,
    output reg_a_cur, reg_f_cur, reg_hl_cur, reg_ip_cur,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len,
    input  z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_hl_in, z80fi_reg_ip_in,
    input  z80fi_reg_a_out, z80fi_reg_f_out, z80fi_reg_hl_out, z80fi_reg_ip_out
`ifdef Z80FI_COLLECT_CHECK_EN
    , input collect_err
`endif
  );

  modport slave (
    input  insn_start, byte_valid, byte_data, insn_done,
    input  reg_a_cur, reg_f_cur, reg_hl_cur, reg_ip_cur,
    output z80fi_valid, z80fi_insn, z80fi_insn_len,
    output z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_hl_in, z80fi_reg_ip_in,
    output z80fi_reg_a_out, z80fi_reg_f_out, z80fi_reg_hl_out, z80fi_reg_ip_out
`ifdef Z80FI_COLLECT_CHECK_EN
    , output collect_err
`endif
  );

endinterface

// File: rtl/z80fi_insn_collector_byte_buf.sv
// rtl/z80fi_insn_collector_byte_buf.sv - little-endian opcode byte buffer with saturating count
// Exposes both current and next contents so the top can retire a record that includes a same-cycle byte.
module z80fi_insn_collector_byte_buf
  import z80fi_insn_collector_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 append_i,
  input  logic [7:0]           byte_i,
  output logic [8*MAX_LEN-1:0] data_q_o,
  output logic [8*MAX_LEN-1:0] data_d_o,
  output logic [LEN_W-1:0]     count_q_o,
  output logic [LEN_W-1:0]     count_d_o,
  output logic                 overflow_o
);

  logic [8*MAX_LEN-1:0] data_q, data_d;
  logic [LEN_W-1:0]     count_q, count_d;

  always_comb begin
    data_d     = data_q;
    count_d    = count_q;
    overflow_o = 1'b0;
    if (load_i) begin
      data_d       = '0;
      data_d[7:0]  = byte_i;
      count_d      = LEN_W'(1);
    end else if (append_i) begin
      if (count_q >= LEN_W'(MAX_LEN)) begin
        overflow_o = 1'b1;
      end else begin
        for (int k = 0; k < MAX_LEN; k++) begin
          if (count_q == LEN_W'(k)) data_d[8*k +: 8] = byte_i;
        end
        count_d = count_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data_q_o  = data_q;
  assign data_d_o  = data_d;
  assign count_q_o = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/z80fi_insn_collector.sv
// rtl/z80fi_insn_collector.sv - assembles fetched opcode bytes and register snapshots into z80fi retirement records
// Optional sticky protocol error flag collect_err is built only with Z80FI_COLLECT_CHECK_EN.
module z80fi_insn_collector
  import z80fi_insn_collector_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input logic                   clk,
  input logic                   reset,
  z80fi_insn_collector_if.slave bus
);

  state_e state_q, state_d;
  logic   retire, err_event;
  logic   buf_append, buf_overflow;

  logic [8*MAX_LEN-1:0] buf_data_q, buf_data_d, rec_insn;
  logic [LEN_W-1:0]     buf_count_q, buf_count_d, rec_len;

  logic [REG8_W-1:0]  snap_a_q, snap_f_q;
  logic [REG16_W-1:0] snap_hl_q, snap_ip_q;
  logic [REG8_W-1:0]  rec_a_in, rec_f_in;
  logic [REG16_W-1:0] rec_hl_in, rec_ip_in;

  logic                 valid_q;
  logic [8*MAX_LEN-1:0] insn_q;
  logic [LEN_W-1:0]     len_q;
  logic [REG8_W-1:0]    a_in_q, f_in_q, a_out_q, f_out_q;
  logic [REG16_W-1:0]   hl_in_q, ip_in_q, hl_out_q, ip_out_q;

  // A byte strobe in a start cycle is the new instruction's first byte, never an append.
  assign buf_append = bus.byte_valid && (state_q == COLLECT) && !bus.insn_start;

  z80fi_insn_collector_byte_buf #(.MAX_LEN(MAX_LEN)) u_byte_buf (
    .clk        (clk),
    .reset      (reset),
    .load_i     (bus.insn_start),
    .append_i   (buf_append),
    .byte_i     (bus.byte_data),
    .data_q_o   (buf_data_q),
    .data_d_o   (buf_data_d),
    .count_q_o  (buf_count_q),
    .count_d_o  (buf_count_d),
    .overflow_o (buf_overflow)
  );

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    err_event = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.insn_start) begin
          retire  = bus.insn_done;
          state_d = bus.insn_done ? IDLE : COLLECT;
        end else begin
          err_event = bus.insn_done;
        end
      end
      COLLECT: begin
        if (bus.insn_done) begin
          retire  = 1'b1;
          state_d = bus.insn_start ? COLLECT : IDLE;
        end else if (bus.insn_start) begin
          err_event = 1'b1;
        end
      end
    endcase
  end

  // Back-to-back retires the old buffer; every other retire sees the buffer after this cycle's update.
  always_comb begin
    rec_insn  = buf_data_d;
    rec_len   = buf_count_d;
    rec_a_in  = snap_a_q;
    rec_f_in  = snap_f_q;
    rec_hl_in = snap_hl_q;
    rec_ip_in = snap_ip_q;
    if (state_q == COLLECT && bus.insn_start) begin
      rec_insn = buf_data_q;
      rec_len  = buf_count_q;
    end
    if (state_q == IDLE) begin
      rec_a_in  = bus.reg_a_cur;
      rec_f_in  = bus.reg_f_cur;
      rec_hl_in = bus.reg_hl_cur;
      rec_ip_in = bus.reg_ip_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      insn_q    <= '0;
      len_q     <= '0;
      snap_a_q  <= '0;
      snap_f_q  <= '0;
      snap_hl_q <= '0;
      snap_ip_q <= '0;
      a_in_q    <= '0;
      f_in_q    <= '0;
      hl_in_q   <= '0;
      ip_in_q   <= '0;
      a_out_q   <= '0;
      f_out_q   <= '0;
      hl_out_q  <= '0;
      ip_out_q  <= '0;
    end else begin
      valid_q <= retire;
      if (bus.insn_start) begin
        snap_a_q  <= bus.reg_a_cur;
        snap_f_q  <= bus.reg_f_cur;
        snap_hl_q <= bus.reg_hl_cur;
        snap_ip_q <= bus.reg_ip_cur;
      end
      if (retire) begin
        insn_q   <= rec_insn;
        len_q    <= rec_len;
        a_in_q   <= rec_a_in;
        f_in_q   <= rec_f_in;
        hl_in_q  <= rec_hl_in;
        ip_in_q  <= rec_ip_in;
        a_out_q  <= bus.reg_a_cur;
        f_out_q  <= bus.reg_f_cur;
        hl_out_q <= bus.reg_hl_cur;
        ip_out_q <= bus.reg_ip_cur;
      end
    end
  end

`ifdef Z80FI_COLLECT_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)                          err_q <= 1'b0;
    else if (err_event || buf_overflow) err_q <= 1'b1;
  end
  assign bus.collect_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_event ^ buf_overflow;
`endif

  assign bus.z80fi_valid      = valid_q;
  assign bus.z80fi_insn       = insn_q;
  assign bus.z80fi_insn_len   = len_q;
  assign bus.z80fi_reg_a_in   = a_in_q;
  assign bus.z80fi_reg_f_in   = f_in_q;
  assign bus.z80fi_reg_hl_in  = hl_in_q;
  assign bus.z80fi_reg_ip_in  = ip_in_q;
  assign bus.z80fi_reg_a_out  = a_out_q;
  assign bus.z80fi_reg_f_out  = f_out_q;
  assign bus.z80fi_reg_hl_out = hl_out_q;
  assign bus.z80fi_reg_ip_out = ip_out_q;

endmodule
